// File: rtl/tap_master.sv
// JTAG host-side sequencer: walks a target TAP through reset / IR shift / DR shift /
// run-test-idle sequences and returns the TDO bits captured during shift states.
module tap_master #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               TCK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  // SYNC: after reset | IDLE: target in Run-Test/Idle | RST: TMS=1 run | HDR: walk to Shift
  // SHIFT: data bits | EXIT: Exit1 -> Update -> Idle | RUN: idle cycles
  localparam logic [2:0] SYNC  = 3'd0;
  localparam logic [2:0] IDLE  = 3'd1;
  localparam logic [2:0] RST   = 3'd2;
  localparam logic [2:0] HDR   = 3'd3;
  localparam logic [2:0] SHIFT = 3'd4;
  localparam logic [2:0] EXIT  = 3'd5;
  localparam logic [2:0] RUN   = 3'd6;

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_DR  = 2'b10;
  localparam logic [1:0] OP_RUN = 2'b11;

  localparam int               IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  logic [2:0]         state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               is_ir_q, is_ir_d;
  logic [MAX_LEN-1:0] sh_q, sh_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               samp_q, samp_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [LEN_W-1:0]   len_c;
  logic               fin;

  always_comb begin
    if (cmd_len == '0)          len_c = CNT_ONE;
    else if (cmd_len > LEN_MAX) len_c = LEN_MAX;
    else                        len_c = cmd_len;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    is_ir_d     = is_ir_q;
    sh_d        = sh_q;
    cap_d       = cap_q;
    idx_d       = idx_q;
    samp_d      = 1'b0;
    tms_d       = tms_q;
    tdi_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    fin         = 1'b0;

    // TDO for a shift bit is valid one edge after that bit was driven
    if (samp_q) begin
      cap_d[idx_q] = TDO;
      idx_d        = idx_q + 1'b1;
    end

    case (state_q)
      SYNC: begin
        tms_d   = 1'b0;
        state_d = IDLE;
      end
      IDLE: begin
        tms_d = 1'b0;
        if (cmd_valid) begin
          len_d   = len_c;
          sh_d    = cmd_data;
          cap_d   = '0;
          idx_d   = '0;
          is_ir_d = (cmd_op == OP_IR);
          case (cmd_op)
            OP_RST: begin
              tms_d   = 1'b1;
              cnt_d   = LEN_W'(4);
              state_d = RST;
            end
            OP_IR: begin
              tms_d   = 1'b1;
              cnt_d   = LEN_W'(3);
              state_d = HDR;
            end
            OP_DR: begin
              tms_d   = 1'b1;
              cnt_d   = LEN_W'(2);
              state_d = HDR;
            end
            default: begin
              tms_d   = 1'b0;
              cnt_d   = len_c - CNT_ONE;
              state_d = RUN;
            end
          endcase
        end
      end
      RST: begin
        if (cnt_q != '0) begin
          tms_d = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          fin = 1'b1;
        end
      end
      HDR: begin
        // only the IR walk has a second TMS=1 (Select-DR -> Select-IR)
        tms_d = is_ir_q && (cnt_q == LEN_W'(3));
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = SHIFT;
          cnt_d   = len_q;
        end
      end
      SHIFT: begin
        tms_d  = (cnt_q == CNT_ONE);
        tdi_d  = sh_q[0];
        sh_d   = {1'b0, sh_q[MAX_LEN-1:1]};
        samp_d = 1'b1;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = EXIT;
          cnt_d   = CNT_ONE;
        end
      end
      EXIT: begin
        if (cnt_q != '0) begin
          tms_d = 1'b1;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          fin = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          tms_d = 1'b0;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          fin = 1'b1;
        end
      end
      default: begin
        tms_d   = 1'b1;
        state_d = SYNC;
      end
    endcase

    if (fin) begin
      tms_d       = 1'b0;
      tdi_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_data_d  = cap_q;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_q     <= SYNC;
      cnt_q       <= '0;
      len_q       <= '0;
      is_ir_q     <= 1'b0;
      sh_q        <= '0;
      cap_q       <= '0;
      idx_q       <= '0;
      samp_q      <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      is_ir_q     <= is_ir_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      idx_q       <= idx_d;
      samp_q      <= samp_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE) && (state_q != SYNC);

endmodule

// File: tb/tb_tap_master.sv
// Bench for tap_master: paired behavioural TAP target, per-cycle TMS/TDI scoreboard,
// response scoreboard with completion-cycle check, and a table of command vectors.
module tb_tap_master;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               TCK = 1'b0;
  logic               TRST = 1'b0;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd_op = 2'b00;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               cmd_ready, rsp_valid, busy, TMS, TDI, TDO;
  logic [MAX_LEN-1:0] rsp_data;

  tap_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .TCK(TCK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 TCK = ~TCK;

  int cyc = 0;
  always @(posedge TCK) cyc <= cyc + 1;

  // ---------------- behavioural target TAP ----------------
  typedef enum logic [3:0] {TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
                            SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
  tap_t        ts;
  logic [63:0] dr_sh = '0, dr_upd = '0, ir_sh = '0, ir_upd = '0;
  logic [63:0] dr_pre = '0, ir_cap = '0;
  int          dr_len = 8, ir_len = 4;
  int          tlr_cnt = 0;

  function automatic tap_t nxt(input tap_t s, input logic m);
    case (s)
      TLR:  return m ? TLR  : RTI;
      RTI:  return m ? SDR  : RTI;
      SDR:  return m ? SIR  : CDR;
      CDR:  return m ? E1DR : SHDR;
      SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR  : PDR;
      PDR:  return m ? E2DR : PDR;
      E2DR: return m ? UDR  : SHDR;
      UDR:  return m ? SDR  : RTI;
      SIR:  return m ? TLR  : CIR;
      CIR:  return m ? E1IR : SHIR;
      SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR  : PIR;
      PIR:  return m ? E2IR : PIR;
      E2IR: return m ? UIR  : SHIR;
      UIR:  return m ? SDR  : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ts <= TLR;
    end else begin
      ts <= nxt(ts, TMS);
      if (ts == TLR) tlr_cnt <= tlr_cnt + 1;
      case (ts)
        CDR:  dr_sh  <= dr_pre;
        SHDR: dr_sh  <= (dr_sh >> 1) | (64'(TDI) << (dr_len - 1));
        UDR:  dr_upd <= dr_sh;
        CIR:  ir_sh  <= ir_cap;
        SHIR: ir_sh  <= (ir_sh >> 1) | (64'(TDI) << (ir_len - 1));
        UIR:  ir_upd <= ir_sh;
        default: ;
      endcase
    end
  end

  assign TDO = (ts == SHDR) ? dr_sh[0] : (ts == SHIR) ? ir_sh[0] : 1'b0;

  // ---------------- scoreboards ----------------
  typedef struct {
    logic [31:0] data;
    int          at;
  } rsp_t;

  logic [1:0] exp_bits[$];   // {TMS, TDI} per cycle from the acceptance edge on
  rsp_t       rsp_q[$];
  int         total = 0;
  int         bad = 0;
  int         rsp_cnt = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  task automatic mon();
    logic [1:0] e;
    rsp_t       r;
    if (TRST) begin
      if (exp_bits.size() > 0) begin
        e = exp_bits.pop_front();
        check("tms", 64'(TMS), 64'(e[1]));
        check("tdi", 64'(TDI), 64'(e[0]));
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(r.data));
          check("rsp_cycle", 64'(cyc), 64'(r.at));
        end
      end
    end
  endtask

  function automatic int clamp_len(input int len);
    if (len == 0) return 1;
    if (len > MAX_LEN) return MAX_LEN;
    return len;
  endfunction

  task automatic push_exp(input logic [1:0] op, input int n, input logic [31:0] d,
                          input logic [31:0] er, input int lat, input int c0);
    case (op)
      2'b00: repeat (5) exp_bits.push_back(2'b10);
      2'b01: begin
        exp_bits.push_back(2'b10); exp_bits.push_back(2'b10);
        exp_bits.push_back(2'b00); exp_bits.push_back(2'b00);
      end
      2'b10: begin
        exp_bits.push_back(2'b10); exp_bits.push_back(2'b00); exp_bits.push_back(2'b00);
      end
      default: repeat (n) exp_bits.push_back(2'b00);
    endcase
    if (op == 2'b01 || op == 2'b10) begin
      for (int i = 0; i < n; i++) exp_bits.push_back({(i == n - 1), d[i]});
      exp_bits.push_back(2'b10);
    end
    exp_bits.push_back(2'b00);
    rsp_q.push_back('{er, c0 + 1 + lat});
  endtask

  task automatic send(input logic [1:0] op, input int len, input logic [31:0] d,
                      input logic [31:0] er, input int lat, output int acc);
    int w;
    @(negedge TCK);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = d;
    w = 0;
    while (!cmd_ready && w < 300) begin
      @(negedge TCK);
      w++;
    end
    check("accept_wait", 64'(cmd_ready), 64'd1);
    #1;
    push_exp(op, clamp_len(len), d, er, lat, cyc);
    @(posedge TCK);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((rsp_q.size() != 0 || exp_bits.size() != 0) && w < 400) begin
      @(negedge TCK);
      w++;
    end
    check("done_wait", 64'(rsp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    int          len;
    logic [31:0] data;
    logic [31:0] pre;
    logic [31:0] rsp;
    int          lat;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[10];

  initial begin : main
    int acc, acc_a, acc_b, acc_c, t0, r0;

    vecs[0] = '{2'b10, 32, 32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF, 36, 32'hDEADBEEF};
    vecs[1] = '{2'b10,  8, 32'h000000A5, 32'h0000003C, 32'h0000003C, 12, 32'h000000A5};
    vecs[2] = '{2'b01,  4, 32'h00000002, 32'h00000001, 32'h00000001,  9, 32'h00000002};
    vecs[3] = '{2'b00,  0, 32'h00000000, 32'h00000000, 32'h00000000,  5, 32'h00000000};
    vecs[4] = '{2'b11,  0, 32'h0000FFFF, 32'h00000000, 32'h00000000,  1, 32'h00000000};
    vecs[5] = '{2'b11,  5, 32'h00000000, 32'h00000000, 32'h00000000,  5, 32'h00000000};
    vecs[6] = '{2'b10,  1, 32'h00000001, 32'h00000000, 32'h00000000,  5, 32'h00000001};
    vecs[7] = '{2'b10,  0, 32'h00000000, 32'h00000001, 32'h00000001,  5, 32'h00000000};
    vecs[8] = '{2'b01,  5, 32'h00000015, 32'h0000000A, 32'h0000000A, 10, 32'h00000015};
    vecs[9] = '{2'b10, 37, 32'h13579BDF, 32'h2468ACE0, 32'h2468ACE0, 36, 32'h13579BDF};

    fork
      forever begin
        @(negedge TCK);
        mon();
      end
    join_none

    // reset and synchronisation
    repeat (3) @(negedge TCK);
    check("rst_tms", 64'(TMS), 64'd1);
    check("rst_tdi", 64'(TDI), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    #2 TRST = 1'b1;
    @(posedge TCK); #1;
    check("sync_tms", 64'(TMS), 64'd0);
    @(posedge TCK); #1;
    check("sync_ready", 64'(cmd_ready), 64'd1);
    check("sync_tgt_rti", 64'(ts == RTI), 64'd1);

    // table of single commands
    for (int k = 0; k < 10; k++) begin
      if (vecs[k].op == 2'b01) begin
        ir_len = clamp_len(vecs[k].len);
        ir_cap = 64'(vecs[k].pre);
      end else begin
        dr_len = clamp_len(vecs[k].len);
        dr_pre = 64'(vecs[k].pre);
      end
      t0 = tlr_cnt;
      send(vecs[k].op, vecs[k].len, vecs[k].data, vecs[k].rsp, vecs[k].lat, acc);
      check("busy_after_accept", 64'(busy), 64'd1);
      wait_idle();
      repeat (2) @(posedge TCK);
      #1;
      check("tgt_rti", 64'(ts == RTI), 64'd1);
      check("rsp_hold", 64'(rsp_data), 64'(vecs[k].rsp));
      check("idle_busy", 64'(busy), 64'd0);
      case (vecs[k].op)
        2'b10:   check("tgt_dr", dr_upd, 64'(vecs[k].tgt));
        2'b01:   check("tgt_ir", ir_upd, 64'(vecs[k].tgt));
        2'b00:   check("tgt_tlr", 64'(tlr_cnt > t0), 64'd1);
        default: check("run_tdi", 64'(TDI), 64'd0);
      endcase
    end

    // back-to-back: run len 0, oversized DR, full-length DR
    dr_len = MAX_LEN;
    dr_pre = 64'h00000000A5A55A5A;
    send(2'b11, 0, 32'h0, 32'h0, 1, acc_a);
    send(2'b10, MAX_LEN + 5, 32'h0BADF00D, 32'hA5A55A5A, 36, acc_b);
    check("b2b_accept_1", 64'(acc_b), 64'(acc_a + 2));
    send(2'b10, MAX_LEN, 32'h600DCAFE, 32'hA5A55A5A, 36, acc_c);
    check("b2b_accept_2", 64'(acc_c), 64'(acc_b + 37));
    wait_idle();
    repeat (2) @(posedge TCK);
    #1;
    check("b2b_tgt_dr", dr_upd, 64'h00000000600DCAFE);

    // TRST while bit 3 of an 8-bit DR shift is on the wire
    dr_len = 8;
    dr_pre = 64'h81;
    send(2'b10, 8, 32'h55, 32'h81, 12, acc);
    repeat (6) @(posedge TCK);
    #1;
    TRST = 1'b0;
    exp_bits.delete();
    rsp_q.delete();
    r0 = rsp_cnt;
    #1;
    check("abort_tms", 64'(TMS), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(cmd_ready), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_rsp_data", 64'(rsp_data), 64'd0);
    repeat (2) @(negedge TCK);
    #2 TRST = 1'b1;
    repeat (10) @(posedge TCK);
    #1;
    check("abort_no_rsp", 64'(rsp_cnt), 64'(r0));
    check("abort_tgt_rti", 64'(ts == RTI), 64'd1);
    send(2'b10, 8, 32'hFF, 32'h81, 12, acc);
    wait_idle();
    repeat (2) @(posedge TCK);
    #1;
    check("abort_fresh_tgt_dr", dr_upd, 64'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tap_master.md
# tap_master

JTAG host-side sequencer: the driving end of the TAP interface. It accepts shift/reset/idle commands on a valid/ready port and generates the TMS/TDI bit stream that walks a target TAP controller through its 16-state machine. It samples TDO during shift states and returns the captured bits on a response port. It sits in the debug/test bench fabric, clocked by the same TCK as the target TAP, and is used for on-chip self-test and for system-level verification of the TAP, IR and DR chain.

## Interface
- MAX_LEN, 32: maximum shift length in bits.
- LEN_W, $clog2(MAX_LEN+1): width of cmd_len.
- TCK  in  1  test clock. All state updates on posedge.
- TRST  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE. Command accepted on a posedge with valid&ready.
- cmd_op  in  2  00 TAP reset, 01 shift IR, 10 shift DR, 11 run-test-idle.
- cmd_len  in  LEN_W  shift bits, or idle cycles. 0 is treated as 1; values above MAX_LEN are clamped to MAX_LEN.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  one-cycle pulse at command completion.
- rsp_data  out  MAX_LEN  captured TDO bits; bit i = i-th sample; bits at len and above are 0.
- busy  out  1  a command is in progress.
- TMS  out  1  registered.
- TDI  out  1  registered.
- TDO  in  1  target serial output; stable before posedge.

## Operation
- The master's FSM states are:
  - SYNC: entered on reset.
  - IDLE
  - RST: 5 TMS=1 bits.
  - HDR: header bits.
  - SHIFT
  - EXIT: TMS=1 to Update.
  - RUN: idle cycles.
- The master mirrors the target state.
- Between commands, the target sits in Run-Test/Idle with TMS=0.
- Latched at acceptance: op, clamped len N, data. A shift register holds TDI; a capture register collects TDO.
- TMS sequences (each bit is one TCK cycle):
  - DR shift: 1,0,0, then N bits (TMS=0 for the first N-1 bits, TMS=1 on the last), then 1, then 0.
  - IR shift: 1,1,0,0, then N bits, then 1, then 0.
  - Reset: 1,1,1,1,1, then 0.
  - Run: 0 for N cycles.
- TDI:
  - During the N shift bits, TDI = data[i].
  - At all other times TDI = 0.

## Timing
- Reset values while TRST=0: TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, state SYNC.
  - TMS=1 holds the target in Test-Logic-Reset.
- First posedge after TRST release: TMS<=0, state<=IDLE. cmd_ready is high from the following cycle.
- Edge numbering:
  - Acceptance edge is E0.
  - The first sequence bit is registered at E0; the target samples it at E1.
  - busy is registered high at E0.
- DR shift:
  - Bit i TDI is registered at E(3+i).
  - TDO is sampled at E(4+i), i=0..N-1.
  - Done edge D=E(N+4).
- IR shift:
  - Bit i TDI is registered at E(4+i).
  - TDO is sampled at E(5+i).
  - Done edge D=E(N+5).
- Reset: D=E5.
- Run: D=E(N).
- At D:
  - TMS<=0, TDI<=0.
  - rsp_valid<=1 for exactly one cycle; rsp_data is valid while rsp_valid is high.
  - cmd_ready<=1, busy<=0.
- Back-to-back: the next command may be accepted at D+1 with no gap in the TMS stream.
- rsp_data holds its value until the next D.
- Reset and run responses: rsp_data=0.
- cmd_valid while busy is ignored; the command stays pending until ready.
- TRST asserted mid-command:
  - All outputs return to reset values immediately.
  - The command is discarded and no rsp_valid is generated.
  - After release, the master re-enters SYNC.
- N=1:
  - The single shift bit carries TMS=1.
  - DR: D=E5.

## Test plan
- Reset sync:
  - Stimulus: hold TRST low 3 cycles, release.
  - Required: TMS=1 during reset; TMS=0 after the first edge; cmd_ready=1 at the second edge; a paired TAP controller reaches Run-Test/Idle.
- DR shift, N=8, data=0xA5, target DR preloaded with 0x3C:
  - Required TMS stream: 1,0,0,0,0,0,0,0,0,0,1,1,0.
  - Required TDI bits: 1,0,1,0,0,1,0,1.
  - Required result: rsp_data=0x3C; rsp_valid pulses once at E12; target DR=0xA5.
- IR shift, N=4, data=0x2, target capture value 0x1:
  - Required TMS stream: 1,1,0,0,0,0,0,1,1,0.
  - Required result: rsp_data=0x1; D=E9; target IR=0x2.
- Reset command issued from Run-Test/Idle:
  - Required: 5 cycles of TMS=1, then TMS=0; the target passes through Test-Logic-Reset; rsp_data=0; D=E5.
- Back-to-back and length boundaries:
  - Stimulus: a run command with len=0, then DR commands with len=MAX_LEN+5 and len=MAX_LEN.
  - Required:
    - The run command lasts 1 cycle.
    - The oversized command shifts exactly MAX_LEN bits.
    - The second command is accepted at D+1.
    - No gap in the stream.
- TRST mid-shift:
  - Stimulus: assert TRST during bit 3 of an 8-bit DR shift.
  - Required:
    - TMS=1 and busy=0 immediately.
    - No rsp_valid.
    - After release, a fresh DR shift of 0xFF completes correctly.
